// File: rtl/fetch_pkg.sv
// Shared types and helpers for the instruction fetch stage.
package fetch_pkg;

  // Fetch FSM encoding
  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HALT  = 2'd2
  } fetch_state_e;

  // Depth of the fetch queue between fetch and decode
  localparam int unsigned QUEUE_DEPTH = 2;

  // One queue entry: the fetched word together with the PC it came from
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fq_entry_t;

  // Reduce a byte PC into the instruction memory span (span must be a power of two)
  function automatic logic [31:0] pc_wrap(input logic [31:0] pc, input logic [31:0] span_bytes);
    return pc & (span_bytes - 32'd1);
  endfunction

  // Sequential next PC, wrapping at the end of instruction memory
  function automatic logic [31:0] pc_plus4(input logic [31:0] pc, input logic [31:0] span_bytes);
    return pc_wrap(pc + 32'd4, span_bytes);
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs for the decode stage.
// A push into a full queue is accepted only when a pop happens in the same cycle.
// Flush empties the queue; stored data is left in place but is never presented as valid.
module fetch_queue
  import fetch_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push_i,
  input  logic      pop_i,
  input  logic      flush_i,
  input  fq_entry_t entry_i,
  output logic      full_o,
  output logic      empty_o,
  output fq_entry_t head_o
);

  localparam int unsigned PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  fq_entry_t          mem_q [QUEUE_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               do_pop_s;
  logic               do_push_s;

  assign full_o  = (count_q == CNT_W'(QUEUE_DEPTH));
  assign empty_o = (count_q == {CNT_W{1'b0}});
  assign head_o  = mem_q[rd_ptr_q];

  // Qualify requests: pop needs data, push needs room (or a concurrent pop)
  always_comb begin
    do_pop_s  = pop_i & ~empty_o;
    do_push_s = push_i & (~full_o | do_pop_s);
  end

  // Storage, pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else if (flush_i) begin
      wr_ptr_q <= {PTR_W{1'b0}};
      rd_ptr_q <= {PTR_W{1'b0}};
      count_q  <= {CNT_W{1'b0}};
    end else begin
      if (do_push_s) begin
        mem_q[wr_ptr_q] <= entry_i;
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      case ({do_push_s, do_pop_s})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, fetch FSM, redirect/halt priority, and a
// 2-entry queue towards decode. Instruction memory is read combinationally.
// Optional build macro: FETCH_MISALIGN_CHK_EN adds misaligned-redirect detection
// and the sticky misalign_exc output.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [29:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        halt_req,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        halted
`ifdef FETCH_MISALIGN_CHK_EN
  ,
  output logic        misalign_exc
`endif
);

  // Byte span of instruction memory; IMEM_WORDS is expected to be a power of two
  localparam logic [31:0] PC_SPAN = 32'(IMEM_WORDS) * 32'd4;

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         push_s;
  logic         pop_s;
  logic         flush_s;
  logic         full_s;
  logic         empty_s;
  fq_entry_t    new_entry_s;
  fq_entry_t    head_s;
`ifdef FETCH_MISALIGN_CHK_EN
  logic         exc_q, exc_d;
`endif

  assign imem_addr   = pc_q[31:2];
  assign id_valid    = ~empty_s;
  assign id_pc       = head_s.pc;
  assign id_instr    = head_s.instr;
  assign halted      = (state_q == S_HALT);
  assign pop_s       = id_valid & id_ready;
  assign new_entry_s = '{pc: pc_q, instr: imem_instr};
`ifdef FETCH_MISALIGN_CHK_EN
  assign misalign_exc = exc_q;
`endif

  // Next-state logic: redirect outranks everything, then the FSM decides push/halt
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    push_s  = 1'b0;
    flush_s = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
    exc_d   = exc_q;
`endif
    if (redirect_valid) begin
      flush_s = 1'b1;
`ifdef FETCH_MISALIGN_CHK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        // Misaligned target: keep the old PC and park until software redirects again
        state_d = S_HALT;
        exc_d   = 1'b1;
      end else begin
        pc_d    = pc_wrap(redirect_pc, PC_SPAN);
        state_d = S_FETCH;
        exc_d   = 1'b0;
      end
`else
      // Low address bits are dropped, the target is folded into memory
      pc_d    = pc_wrap(redirect_pc & 32'hFFFF_FFFC, PC_SPAN);
      state_d = S_FETCH;
`endif
    end else begin
      case (state_q)
        S_BOOT: begin
          state_d = S_FETCH;
        end
        S_FETCH: begin
          if (halt_req) begin
            state_d = S_HALT;
          end else if (!full_s || pop_s) begin
            push_s = 1'b1;
            pc_d   = pc_plus4(pc_q, PC_SPAN);
          end else begin
            // Queue full with no pop: hold the PC so imem_addr stays stable
            pc_d = pc_q;
          end
        end
        S_HALT: begin
          state_d = S_HALT;
        end
        default: begin
          state_d = S_BOOT;
        end
      endcase
    end
  end

  // PC and FSM state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_BOOT;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
    end
  end

`ifdef FETCH_MISALIGN_CHK_EN
  // Sticky misaligned-redirect flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exc_q <= 1'b0;
    end else begin
      exc_q <= exc_d;
    end
  end
`endif

  fetch_queue u_queue (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .pop_i   (pop_s),
    .flush_i (flush_s),
    .entry_i (new_entry_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .head_o  (head_s)
  );

endmodule
